// File: rtl/conv_operand_buffer.sv
// conv_operand_buffer: loads an image and a filter from a byte stream, then streams every convolution window as (pixel, weight) pairs.
module conv_operand_buffer #(
    parameter int DW    = 8,
    parameter int IMG_W = 4,
    parameter int IMG_H = 4,
    parameter int K     = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          replay,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_pix,
    output logic [DW-1:0] out_wgt,
    output logic          out_win_last,
    output logic          out_frame_last,
    output logic          done_memory,
    output logic          busy
);
    localparam int OW = IMG_W - K + 1;
    localparam int OH = IMG_H - K + 1;
    localparam int NI = IMG_W * IMG_H;
    localparam int NF = K * K;
    localparam int AW = NI > 1 ? $clog2(NI) : 1;
    localparam int FW = NF > 1 ? $clog2(NF) : 1;
    localparam int KW = K > 1 ? $clog2(K) : 1;
    localparam int XW = OW > 1 ? $clog2(OW) : 1;
    localparam int YW = OH > 1 ? $clog2(OH) : 1;

    typedef enum logic [2:0] {IDLE, LOAD_IMG, LOAD_FLT, LOADED, STREAM} state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic [KW-1:0] kx, ky;
    logic [XW-1:0] ox;
    logic [YW-1:0] oy;
    logic [DW-1:0] img [NI];
    logic [DW-1:0] flt [NF];
    logic [AW-1:0] pix_idx;
    logic [FW-1:0] wgt_idx;
    logic          win_last, frame_last;

    always_comb begin
        pix_idx    = AW'((int'(oy) + int'(ky)) * IMG_W + int'(ox) + int'(kx));
        wgt_idx    = FW'(int'(ky) * K + int'(kx));
        win_last   = int'(kx) == K - 1 && int'(ky) == K - 1;
        frame_last = win_last && int'(ox) == OW - 1 && int'(oy) == OH - 1;
    end

    // Pair outputs are forced to zero outside STREAM so idle outputs stay clean.
    assign out_pix        = out_valid ? img[pix_idx] : '0;
    assign out_wgt        = out_valid ? flt[wgt_idx] : '0;
    assign out_win_last   = out_valid && win_last;
    assign out_frame_last = out_valid && frame_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            kx          <= '0;
            ky          <= '0;
            ox          <= '0;
            oy          <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            done_memory <= 1'b0;
            busy        <= 1'b0;
            for (int i = 0; i < NI; i++) img[i] <= '0;
            for (int i = 0; i < NF; i++) flt[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= LOAD_IMG;
                        cnt         <= '0;
                        done_memory <= 1'b0;
                        in_ready    <= 1'b1;
                        busy        <= 1'b1;
                    end else if (replay && done_memory) begin
                        state     <= STREAM;
                        kx        <= '0;
                        ky        <= '0;
                        ox        <= '0;
                        oy        <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LOAD_IMG: if (in_valid) begin
                    img[cnt] <= in_data;
                    cnt      <= int'(cnt) == NI - 1 ? '0 : cnt + 1'b1;
                    state    <= int'(cnt) == NI - 1 ? LOAD_FLT : LOAD_IMG;
                end
                LOAD_FLT: if (in_valid) begin
                    flt[FW'(cnt)] <= in_data;
                    cnt           <= cnt + 1'b1;
                    if (int'(cnt) == NF - 1) begin
                        state       <= LOADED;
                        in_ready    <= 1'b0;
                        done_memory <= 1'b1;
                    end
                end
                LOADED: begin
                    state     <= STREAM;
                    kx        <= '0;
                    ky        <= '0;
                    ox        <= '0;
                    oy        <= '0;
                    out_valid <= 1'b1;
                end
                STREAM: if (out_ready) begin
                    if (int'(kx) != K - 1) kx <= kx + 1'b1;
                    else begin
                        kx <= '0;
                        if (int'(ky) != K - 1) ky <= ky + 1'b1;
                        else begin
                            ky <= '0;
                            if (int'(ox) != OW - 1) ox <= ox + 1'b1;
                            else begin
                                ox <= '0;
                                if (int'(oy) != OH - 1) oy <= oy + 1'b1;
                                else begin
                                    oy        <= '0;
                                    state     <= IDLE;
                                    out_valid <= 1'b0;
                                    busy      <= 1'b0;
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_operand_buffer.sv
// tb_conv_operand_buffer: random and directed load/stream runs checked against a window-enumeration model.
module tb_conv_operand_buffer;
    localparam int DW = 8, IMG_W = 4, IMG_H = 4, K = 3;
    localparam int OW = IMG_W - K + 1, OH = IMG_H - K + 1;
    localparam int NI = IMG_W * IMG_H, NF = K * K, NB = OW * OH * NF;

    logic          clk = 0, rst = 1, start = 0, replay = 0, in_valid = 0, out_ready = 0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, out_win_last, out_frame_last, done_memory, busy;
    logic [DW-1:0] out_pix, out_wgt;

    logic [DW-1:0] m_img [NI];
    logic [DW-1:0] m_flt [NF];
    int n_tests = 0, n_fail = 0;

    conv_operand_buffer #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) dut (
        .clk(clk), .rst(rst), .start(start), .replay(replay),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .out_wgt(out_wgt),
        .out_win_last(out_win_last), .out_frame_last(out_frame_last),
        .done_memory(done_memory), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // stop_at < NI+NF aborts the load after that many beats.
    task automatic load(input bit gaps, input bit rnd, input int stop_at);
        int rdy = 0;
        for (int i = 0; i < NI; i++) m_img[i] = rnd ? DW'($urandom) : DW'(i + 1);
        for (int i = 0; i < NF; i++) m_flt[i] = rnd ? DW'($urandom) : DW'(i + 1);
        if (gaps) begin
            in_valid = 1;
            in_data  = DW'($urandom);
            tick();
            chk("idle_in_valid_busy", busy, 0);
        end
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < NI + NF && i < stop_at; i++) begin
            if (gaps) begin
                in_valid = 0;
                in_data  = DW'($urandom);
                rdy += int'(in_ready);
                tick();
            end
            in_valid = 1;
            in_data  = i < NI ? m_img[i] : m_flt[i - NI];
            rdy += int'(in_ready);
            tick();
        end
        in_valid = 0;
        if (stop_at >= NI + NF) begin
            chk("load_ready_cycles", rdy, gaps ? 2 * (NI + NF) : NI + NF);
            chk("loaded_in_ready", in_ready, 0);
            chk("loaded_done", done_memory, 1);
            chk("loaded_out_valid", out_valid, 0);
            chk("loaded_busy", busy, 1);
        end
    endtask

    // mode 0: always ready, 1: 3-cycle stall at beat 4, 2: random backpressure.
    task automatic stream(input bit from_replay, input int mode, input bit poke);
        int b = 0, cyc = 0, hold = 0;
        int kx, ky, ox, oy;
        if (from_replay) replay = 1;
        tick();
        replay = 0;
        while (b < NB && cyc < 1000) begin
            kx = b % K;
            ky = (b / K) % K;
            ox = (b / NF) % OW;
            oy = b / (NF * OW);
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? !(b == 4 && hold < 3) : ($urandom_range(0, 3) != 0);
            if (!out_ready) hold++;
            if (poke) begin
                start    = 1'($urandom);
                in_valid = 1'($urandom);
                in_data  = DW'($urandom);
            end
            chk("out_valid", out_valid, 1);
            chk("out_pix", out_pix, m_img[(oy + ky) * IMG_W + ox + kx]);
            chk("out_wgt", out_wgt, m_flt[ky * K + kx]);
            chk("win_last", out_win_last, kx == K - 1 && ky == K - 1);
            chk("frame_last", out_frame_last, b == NB - 1);
            tick();
            if (out_ready) b++;
            cyc++;
        end
        start     = 0;
        in_valid  = 0;
        out_ready = 0;
        if (b < NB) chk("stream_timeout", b, NB);
        if (mode != 2) chk("stream_cycles", cyc, mode == 1 ? NB + 3 : NB);
        chk("end_out_valid", out_valid, 0);
        chk("end_busy", busy, 0);
        chk("end_done", done_memory, 1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            start    = 1'($urandom);
            replay   = 1'($urandom);
            in_valid = 1'($urandom);
            in_data  = DW'($urandom);
            out_ready = 1'($urandom);
            tick();
            chk("reset_outputs", {in_ready, out_valid, out_pix, out_wgt, out_win_last,
                                  out_frame_last, done_memory, busy}, 0);
        end
        start = 0; replay = 0; in_valid = 0; out_ready = 0;
        rst = 0;
        tick();
        replay = 1;
        tick();
        replay = 0;
        tick();
        chk("replay_ignored_busy", busy, 0);
        chk("replay_ignored_valid", out_valid, 0);

        load(0, 0, NI + NF);
        stream(0, 0, 0);
        stream(1, 1, 0);
        load(1, 0, NI + NF);
        stream(0, 0, 1);
        stream(1, 0, 0);
        for (int r = 0; r < 3; r++) begin
            load(1'($urandom), 1, NI + NF);
            stream(0, 2, 1);
        end

        load(0, 1, NI + 4);
        rst = 1;
        #1;
        chk("abort_done", done_memory, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_busy", busy, 0);
        tick();
        rst = 0;
        tick();
        load(0, 1, NI + NF);
        stream(0, 2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
